pipe_stage_sequencer: RTL and testbench
=======================================

# pipe_stage_sequencer

Programmable stage scheduler that sequences the fp16 pipe datapath (add/mul/reduction lanes) through up to eight compute stages. It holds the per-stage step boundaries and a reduction-clear mask, and runs the step counter under a start/stall/done handshake. Each cycle it drives the stage index, the datapath mode select and a one-cycle reduction-register clear pulse. It sits between the tile-level control FSM and the pipe stage datapath, replacing free-running step counting with an explicit, stallable, restartable run.

## Interface
Parameters:
- STEP_W, 16, width of step counter and boundary registers
- NUM_STAGES, 8, number of programmable boundaries (stage indices 0..NUM_STAGES; NUM_STAGES = finished)
- STAGE_W, 5, width of stage_o

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- cfg_we_i  in  1  boundary write strobe
- cfg_idx_i  in  3  boundary index 0..7
- cfg_bound_i  in  STEP_W  boundary value, written to bound[cfg_idx_i]
- clr_mask_i  in  NUM_STAGES  bit k=1: pulse red_clr_o on entering boundary k; sampled on accepted start
- start_i  in  1  run request
- stall_i  in  1  hold step counter this cycle
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse, run complete
- cfg_err_o  out  1  sticky: last start rejected (non-monotonic bounds)
- step_o  out  STEP_W  current step
- stage_o  out  STAGE_W  current stage index
- mode_o  out  1  1 while stage_o is 0 or 1 in RUN, else 0
- red_clr_o  out  1  reduction-register clear pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE: cfg_we_i writes bound[cfg_idx_i] <= cfg_bound_i. cfg writes in RUN or DONE are ignored.
- Accepted start in IDLE requires bound[0] <= bound[1] <= ... <= bound[7]:
  - step_o <= 0, mask latched, cfg_err_o <= 0.
  - Next state is RUN, or DONE directly when bound[7] == 0.
- Rejected start: cfg_err_o <= 1, stay IDLE.
- start_i in RUN or DONE is ignored.
- RUN: stage_o = smallest k with step_o < bound[k]; equal bounds give zero-length stages, which are skipped.
- RUN step update: if stall_i=0, step_o <= step_o + 1; stall_i=1 holds step_o and all state.
- RUN exit: when step_o == bound[7]-1 and stall_i=0, next state DONE with step_o = bound[7].
- DONE: stage_o = 8, done_o = 1, busy_o = 0. Next state IDLE unconditionally.
- IDLE outputs: stage_o = 0, mode_o = 0, busy_o = 0. step_o holds its last value.
- red_clr_o = RUN & ~stall_i & (OR over k of latched_mask[k] & step_o == bound[k] & bound[k] != 0).
  - Fires exactly once per masked nonzero boundary, even under stall.
  - Several boundaries sharing one value give one pulse.
- Arithmetic: unsigned compares on STEP_W bits. step_o never wraps because the run ends at bound[7] <= 2^STEP_W-1.

## Timing
- Reset (rst_ni=0 at edge):
  - State IDLE, step_o = 0.
  - All bound and latched mask registers 0.
  - cfg_err_o = 0, busy_o = 0, done_o = 0, red_clr_o = 0, stage_o = 0, mode_o = 0.
- Reset asserted mid-run aborts the run at that edge with no done_o pulse.
- Start sampled at edge t. RUN (busy_o=1, step_o=0) is visible from cycle t+1.
- Unstalled run of N = bound[7] steps: RUN spans cycles t+1..t+N, done_o is high in cycle t+N+1, IDLE from t+N+2. Each stalled cycle adds one cycle.
- Output sources:
  - Registered: state, step_o, cfg_err_o.
  - Combinational, decoded from registered state and step_o: stage_o, mode_o, busy_o, done_o.
  - Combinational: red_clr_o; its only same-cycle input dependency is stall_i.
- A cfg write and a start in the same IDLE cycle: the write takes effect first, and the start validates the updated bounds.
- Earliest restart is start_i in the IDLE cycle following DONE.

## Test plan
- Bounds {2,4,4,6,6,6,6,8}, mask 8'b0111_0010, no stall -> stage_o sequence 0,0,1,1,3,3,7,7 over steps 0..7; mode_o=1 for steps 0..3; red_clr_o at steps 4 and 6 only; done_o 9 cycles after start.
- Same config, stall_i=1 on steps 3 and 4 for 2 cycles each -> step_o holds; red_clr_o pulses once at step 4 in its unstalled cycle; done_o 13 cycles after start.
- Bounds {5,3,...} then start -> cfg_err_o=1, busy_o stays 0. Fix bound[1]=5, then start -> cfg_err_o clears and the run proceeds.
- All bounds 0, start -> next cycle DONE with done_o=1 and stage_o=8, no RUN cycle, no red_clr_o.
- rst_ni=0 at step 3 of a run -> next cycle all outputs at reset values, bounds read 0, no done_o pulse.
- cfg write to bound[7] during RUN -> ignored, run ends at the originally programmed step; start_i held high through RUN -> no restart until the IDLE cycle after DONE.

Source files
------------

// File: rtl/pipe_stage_sequencer.sv
// ---------------------------------------------------------------------------
// pipe_stage_sequencer
//
// Programmable stage scheduler for the fp16 pipe datapath. Holds up to
// NUM_STAGES step boundaries and a reduction-clear mask, and runs a
// stallable step counter through IDLE -> RUN -> DONE.
//
// Ports:
//   clk_i        clock, all logic on rising edge
//   rst_ni       synchronous active-low reset
//   cfg_we_i     boundary write strobe (honoured in IDLE only)
//   cfg_idx_i    boundary index 0..7
//   cfg_bound_i  boundary value written to bound[cfg_idx_i]
//   clr_mask_i   bit k: pulse red_clr_o on entering boundary k (latched at start)
//   start_i      run request
//   stall_i      hold step counter this cycle
//   busy_o       high in RUN
//   done_o       one-cycle pulse when the run completes
//   cfg_err_o    sticky: last start rejected (non-monotonic bounds)
//   step_o       current step
//   stage_o      current stage index (NUM_STAGES = finished)
//   mode_o       1 while stage_o is 0 or 1 in RUN
//   red_clr_o    reduction-register clear pulse
//   dbg_state_o  FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
//
// Handshake: start_i acts as a valid and the sequencer is ready only in
// IDLE; a start is consumed on the edge where start_i=1 and state is IDLE.
// start_i in any other state is dropped, not queued. done_o is a one-cycle
// pulse with no back-pressure; stall_i holds the counter and every state
// bit for the cycle in which it is high.
// ---------------------------------------------------------------------------
module pipe_stage_sequencer #(
    parameter int STEP_W     = 16,
    parameter int NUM_STAGES = 8,
    parameter int STAGE_W    = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_we_i,
    input  logic [2:0]            cfg_idx_i,
    input  logic [STEP_W-1:0]     cfg_bound_i,
    input  logic [NUM_STAGES-1:0] clr_mask_i,
    input  logic                  start_i,
    input  logic                  stall_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cfg_err_o,
    output logic [STEP_W-1:0]     step_o,
    output logic [STAGE_W-1:0]    stage_o,
    output logic                  mode_o,
    output logic                  red_clr_o,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [STEP_W-1:0]       step_q;
    logic                    cfg_err_q;
    logic [NUM_STAGES-1:0]   mask_q;
    logic [STEP_W-1:0]       bound_q   [NUM_STAGES];
    logic [STEP_W-1:0]       bound_nxt [NUM_STAGES];

    logic                    bounds_ok;
    logic [STAGE_W-1:0]      stage_run;
    logic                    bound_hit;
    logic [STEP_W-1:0]       last_bound;

    // Boundary file with the IDLE write applied, so a start in the same
    // cycle as a write validates the updated values.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            bound_nxt[k] = bound_q[k];
            if (state_q == ST_IDLE && cfg_we_i && cfg_idx_i == 3'(k)) begin
                bound_nxt[k] = cfg_bound_i;
            end
        end
    end

    always_comb begin
        bounds_ok = 1'b1;
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (bound_nxt[k] < bound_nxt[k-1]) begin
                bounds_ok = 1'b0;
            end
        end
    end

    assign last_bound = bound_q[NUM_STAGES-1];

    // Smallest k with step < bound[k]; scanning downward lets the lowest
    // match win, which also skips zero-length stages.
    always_comb begin
        stage_run = STAGE_W'(NUM_STAGES);
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (step_q < bound_q[k]) begin
                stage_run = STAGE_W'(k);
            end
        end
    end

    // Shared boundary values collapse into a single OR term, giving one
    // pulse. The pulse is gated by stall so it lands in the cycle that
    // actually leaves the boundary step.
    always_comb begin
        bound_hit = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (mask_q[k] && step_q == bound_q[k] && bound_q[k] != '0) begin
                bound_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            cfg_err_q <= 1'b0;
            mask_q    <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                bound_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                bound_q[k] <= bound_nxt[k];
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (bounds_ok) begin
                            step_q    <= '0;
                            mask_q    <= clr_mask_i;
                            cfg_err_q <= 1'b0;
                            state_q   <= (bound_nxt[NUM_STAGES-1] == '0) ? ST_DONE : ST_RUN;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!stall_i) begin
                        step_q <= step_q + STEP_W'(1);
                        if (step_q == last_bound - STEP_W'(1)) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = (state_q == ST_RUN);
    assign done_o      = (state_q == ST_DONE);
    assign cfg_err_o   = cfg_err_q;
    assign step_o      = step_q;
    assign stage_o     = (state_q == ST_RUN)  ? stage_run :
                         (state_q == ST_DONE) ? STAGE_W'(NUM_STAGES) : '0;
    assign mode_o      = (state_q == ST_RUN) && (stage_run <= STAGE_W'(1));
    assign red_clr_o   = (state_q == ST_RUN) && !stall_i && bound_hit;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_sequencer
//
// Directed bench for pipe_stage_sequencer. Each observed cycle is packed as
// {busy, done, stage[4:0], mode, red_clr, step[15:0]} and compared against a
// hand-computed entry popped from exp_q; stall_q carries the stall_i value
// to drive in that same cycle.
// ---------------------------------------------------------------------------
module tb_pipe_stage_sequencer;

    localparam int STEP_W     = 16;
    localparam int NUM_STAGES = 8;
    localparam int STAGE_W    = 5;
    localparam int VW         = 2 + STAGE_W + 2 + STEP_W;

    logic                  clk_i;
    logic                  rst_ni;
    logic                  cfg_we_i;
    logic [2:0]            cfg_idx_i;
    logic [STEP_W-1:0]     cfg_bound_i;
    logic [NUM_STAGES-1:0] clr_mask_i;
    logic                  start_i;
    logic                  stall_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  cfg_err_o;
    logic [STEP_W-1:0]     step_o;
    logic [STAGE_W-1:0]    stage_o;
    logic                  mode_o;
    logic                  red_clr_o;
    logic [1:0]            dbg_state_o;

    pipe_stage_sequencer #(
        .STEP_W     (STEP_W),
        .NUM_STAGES (NUM_STAGES),
        .STAGE_W    (STAGE_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cfg_we_i    (cfg_we_i),
        .cfg_idx_i   (cfg_idx_i),
        .cfg_bound_i (cfg_bound_i),
        .clr_mask_i  (clr_mask_i),
        .start_i     (start_i),
        .stall_i     (stall_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cfg_err_o   (cfg_err_o),
        .step_o      (step_o),
        .stage_o     (stage_o),
        .mode_o      (mode_o),
        .red_clr_o   (red_clr_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard state ----------------
    logic [VW-1:0] exp_q[$];
    logic          stall_q[$];
    int            n_pass  = 0;
    int            n_total = 0;
    string         cur_test = "reset";

    function automatic logic [VW-1:0] mk(input logic b, input logic d, input int stage,
                                         input logic m, input logic r, input int step);
        logic [STAGE_W-1:0] st;
        logic [STEP_W-1:0]  sp;
        st = STAGE_W'(stage);
        sp = STEP_W'(step);
        return {b, d, st, m, r, sp};
    endfunction

    function automatic logic [VW-1:0] obs();
        return {busy_o, done_o, stage_o, mode_o, red_clr_o, step_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s/%s observed=%0h expected=%0h", cur_test, tag, observed, expected);
    endtask

    // ---------------- driver tasks ----------------
    // Every task starts and ends 1 time unit after a rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [VW-1:0] e, input logic s);
        exp_q.push_back(e);
        stall_q.push_back(s);
    endtask

    task automatic drain();
        logic [VW-1:0] e;
        while (exp_q.size() > 0) begin
            stall_i = stall_q.pop_front();
            e = exp_q.pop_front();
            #1;
            check($sformatf("cyc_step%0d", e[STEP_W-1:0]), 32'(obs()), 32'(e));
            cyc();
        end
        stall_i = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input int val);
        cfg_we_i    = 1'b1;
        cfg_idx_i   = 3'(idx);
        cfg_bound_i = STEP_W'(val);
        cyc();
        cfg_we_i    = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int st_tbl [8];
        int md_tbl [8];
        int rc_tbl [8];
        int b1_tbl [8];
        int i;
        rst_ni = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_bound_i = '0;
        clr_mask_i = '0; start_i = 1'b0; stall_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset values
        #1;
        check("rst_outs", 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0)));
        check("rst_err", 32'(cfg_err_o), 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        rst_ni = 1'b1;
        cyc();

        // Test 1: bounds {2,4,4,6,6,6,6,8}, mask 0111_0010, no stall
        cur_test = "basic";
        b1_tbl = '{2, 4, 4, 6, 6, 6, 6, 8};
        st_tbl = '{0, 0, 1, 1, 3, 3, 7, 7};
        md_tbl = '{1, 1, 1, 1, 0, 0, 0, 0};
        rc_tbl = '{0, 0, 0, 0, 1, 0, 1, 0};
        for (int k = 0; k < 8; k++) cfg_write(k, b1_tbl[k]);
        clr_mask_i = 8'b0111_0010;
        pulse_start();
        for (int k = 0; k < 8; k++) push(mk(1, 0, st_tbl[k], md_tbl[k][0], rc_tbl[k][0], k), 1'b0);
        push(mk(0, 1, 8, 0, 0, 8), 1'b0);
        push(mk(0, 0, 0, 0, 0, 8), 1'b0);
        drain();

        // Test 2: same config, stall steps 3 and 4 for two cycles each
        cur_test = "stall";
        pulse_start();
        push(mk(1, 0, 0, 1, 0, 0), 1'b0);
        push(mk(1, 0, 0, 1, 0, 1), 1'b0);
        push(mk(1, 0, 1, 1, 0, 2), 1'b0);
        push(mk(1, 0, 1, 1, 0, 3), 1'b1);
        push(mk(1, 0, 1, 1, 0, 3), 1'b1);
        push(mk(1, 0, 1, 1, 0, 3), 1'b0);
        push(mk(1, 0, 3, 0, 0, 4), 1'b1);
        push(mk(1, 0, 3, 0, 0, 4), 1'b1);
        push(mk(1, 0, 3, 0, 1, 4), 1'b0);
        push(mk(1, 0, 3, 0, 0, 5), 1'b0);
        push(mk(1, 0, 7, 0, 1, 6), 1'b0);
        push(mk(1, 0, 7, 0, 0, 7), 1'b0);
        push(mk(0, 1, 8, 0, 0, 8), 1'b0);
        push(mk(0, 0, 0, 0, 0, 8), 1'b0);
        drain();

        // Test 3: non-monotonic bounds rejected, then fixed with a write
        // in the same cycle as the start
        cur_test = "cfg_err";
        b1_tbl = '{5, 3, 5, 5, 5, 5, 5, 6};
        for (int k = 0; k < 8; k++) cfg_write(k, b1_tbl[k]);
        clr_mask_i = 8'b0000_0011;
        pulse_start();
        #1;
        check("err_set", 32'(cfg_err_o), 32'd1);
        check("err_busy", 32'(busy_o), 32'd0);
        cyc();
        check("err_sticky", 32'(cfg_err_o), 32'd1);
        cfg_we_i = 1'b1; cfg_idx_i = 3'd1; cfg_bound_i = 16'd5;
        start_i  = 1'b1;
        cyc();
        cfg_we_i = 1'b0; start_i = 1'b0;
        for (int k = 0; k < 5; k++) push(mk(1, 0, 0, 1, 0, k), 1'b0);
        push(mk(1, 0, 7, 0, 1, 5), 1'b0);
        push(mk(0, 1, 8, 0, 0, 6), 1'b0);
        push(mk(0, 0, 0, 0, 0, 6), 1'b0);
        drain();
        check("err_cleared", 32'(cfg_err_o), 32'd0);

        // Test 4: all bounds zero -> straight to DONE
        cur_test = "zero";
        for (int k = 0; k < 8; k++) cfg_write(k, 0);
        clr_mask_i = 8'hFF;
        pulse_start();
        push(mk(0, 1, 8, 0, 0, 0), 1'b0);
        push(mk(0, 0, 0, 0, 0, 0), 1'b0);
        drain();

        // Test 5: reset during step 3 of a run
        cur_test = "midreset";
        for (int k = 0; k < 8; k++) cfg_write(k, k + 1);
        pulse_start();
        push(mk(1, 0, 0, 1, 0, 0), 1'b0);
        push(mk(1, 0, 1, 1, 1, 1), 1'b0);
        push(mk(1, 0, 2, 0, 1, 2), 1'b0);
        drain();
        #1;
        check("pre_rst_step", 32'(step_o), 32'd3);
        rst_ni = 1'b0;
        cyc();
        push(mk(0, 0, 0, 0, 0, 0), 1'b0);
        drain();
        check("rst_err2", 32'(cfg_err_o), 32'd0);
        rst_ni = 1'b1;
        push(mk(0, 0, 0, 0, 0, 0), 1'b0);
        push(mk(0, 0, 0, 0, 0, 0), 1'b0);
        drain();
        // Bounds were cleared by reset, so a bare start goes straight to DONE
        pulse_start();
        push(mk(0, 1, 8, 0, 0, 0), 1'b0);
        push(mk(0, 0, 0, 0, 0, 0), 1'b0);
        drain();

        // Test 6: cfg write in RUN ignored; start held high restarts only
        // from the IDLE cycle after DONE
        cur_test = "hold";
        b1_tbl = '{2, 2, 2, 2, 2, 2, 2, 4};
        for (int k = 0; k < 8; k++) cfg_write(k, b1_tbl[k]);
        clr_mask_i = '0;
        start_i = 1'b1;
        cyc();
        push(mk(1, 0, 0, 1, 0, 0), 1'b0);
        drain();
        cfg_we_i = 1'b1; cfg_idx_i = 3'd7; cfg_bound_i = 16'd2;
        push(mk(1, 0, 0, 1, 0, 1), 1'b0);
        drain();
        cfg_we_i = 1'b0;
        push(mk(1, 0, 7, 0, 0, 2), 1'b0);
        push(mk(1, 0, 7, 0, 0, 3), 1'b0);
        push(mk(0, 1, 8, 0, 0, 4), 1'b0);
        push(mk(0, 0, 0, 0, 0, 4), 1'b0);
        push(mk(1, 0, 0, 1, 0, 0), 1'b0);
        drain();
        start_i = 1'b0;
        i = 0;
        while (i < 20 && done_o !== 1'b1) begin
            cyc();
            i++;
        end
        check("restart_done", 32'(done_o), 32'd1);
        check("restart_step", 32'(step_o), 32'd4);
        cyc();
        check("final_idle", 32'(dbg_state_o), 32'd0);
        check("final_busy", 32'(busy_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
